// File: rtl/train_pkg.sv
// train_pkg: shared direction codes, interlock states and round-robin helper
package train_pkg;
    localparam logic [1:0] DIR_GO   = 2'b01;
    localparam logic [1:0] DIR_STOP = 2'b00;
    typedef enum logic [1:0] {IDLE, OCCUPIED, FAULT} state_t;
    function automatic int next_rr(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: level after DEBOUNCE_CYCLES consecutive high samples, one-cycle rise pulse
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic Clock,
    input  logic RESET,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          w_level_nx;
    assign w_cnt_nx   = !raw ? '0 : (r_cnt == CW'(DEBOUNCE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    assign w_level_nx = (w_cnt_nx == CW'(DEBOUNCE_CYCLES));
    always_ff @(posedge Clock or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            rise  <= w_level_nx & ~level;
            level <= w_level_nx;
        end
    end
endmodule

// File: rtl/train_section_interlock.sv
// train_section_interlock: round-robin grant of one shared track section to NUM_TRAINS trains
// with debounced sensors, per-train GO/STOP commands and a latched watchdog fault.
module train_section_interlock
    import train_pkg::*;
#(
    parameter  int NUM_TRAINS      = 2,
    parameter  int DEBOUNCE_CYCLES = 2,
    parameter  int TIMEOUT_CYCLES  = 64,
    localparam int ID_W            = $clog2(NUM_TRAINS)
) (
    input  logic                    Clock,
    input  logic                    RESET,
    input  logic [NUM_TRAINS-1:0]   entry_sr,
    input  logic [NUM_TRAINS-1:0]   exit_sr,
    output logic [2*NUM_TRAINS-1:0] dir,
    output logic [ID_W-1:0]         route,
    output logic                    busy,
    output logic                    fault
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [NUM_TRAINS-1:0]   w_entry_ev, w_exit_ev, w_owner_mask, w_pend, w_pend_nx, r_pending;
    logic [2*NUM_TRAINS-1:0] w_unused_lvl, w_dir_nx, r_dir;
    logic [ID_W-1:0]         r_route, w_route_nx, r_rr, w_rr_nx, w_base, w_win;
    logic [TW-1:0]           r_timer, w_timer_nx;
    logic                    w_release, w_bad_exit, w_timeout, w_grant, r_busy, r_fault;
    state_t                  r_state, w_state_nx;

    genvar t;
    for (t = 0; t < NUM_TRAINS; t++) begin : g_sensor
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
            .Clock(Clock), .RESET(RESET), .raw(entry_sr[t]), .level(w_unused_lvl[2*t]), .rise(w_entry_ev[t])
        );
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
            .Clock(Clock), .RESET(RESET), .raw(exit_sr[t]), .level(w_unused_lvl[2*t+1]), .rise(w_exit_ev[t])
        );
    end

    // route doubles as the owner index while OCCUPIED
    assign w_owner_mask = (r_state == OCCUPIED) ? NUM_TRAINS'(1) << r_route : '0;
    assign w_pend       = r_pending | ((r_state == FAULT) ? '0 : w_entry_ev & ~w_owner_mask);
    assign w_release    = (r_state == OCCUPIED) && w_exit_ev[r_route];
    assign w_bad_exit   = (r_state != FAULT) && |(w_exit_ev & ~w_owner_mask);
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_state == OCCUPIED) &&
                          (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_base       = w_release ? ID_W'(next_rr(int'(r_route), NUM_TRAINS)) : r_rr;

    // descending scan so the request closest to the pointer is written last and wins
    always_comb begin
        w_win = w_base;
        for (int k = NUM_TRAINS - 1; k >= 0; k--)
            if (w_pend[ID_W'((int'(w_base) + k) % NUM_TRAINS)]) w_win = ID_W'((int'(w_base) + k) % NUM_TRAINS);
    end

    always_comb begin
        w_state_nx = r_state;
        w_rr_nx    = w_release ? w_base : r_rr;
        w_timer_nx = (&r_timer) ? r_timer : r_timer + 1'b1;
        w_grant    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nx = w_bad_exit ? FAULT : IDLE;
                w_grant    = !w_bad_exit && |w_pend;
            end
            OCCUPIED: begin
                w_state_nx = w_bad_exit ? FAULT : w_release ? IDLE : w_timeout ? FAULT : OCCUPIED;
                w_grant    = !w_bad_exit && w_release && |w_pend;
            end
            default: w_state_nx = FAULT;
        endcase
        w_route_nx = w_grant ? w_win : r_route;
        w_pend_nx  = w_pend;
        if (w_grant) begin
            w_pend_nx[w_win] = 1'b0;
            w_state_nx       = OCCUPIED;
            w_timer_nx       = '0;
        end
        for (int i = 0; i < NUM_TRAINS; i++)
            w_dir_nx[2*i +: 2] = (w_state_nx == FAULT ||
                                  (w_state_nx == OCCUPIED && i != int'(w_route_nx) && w_pend_nx[i])) ? DIR_STOP : DIR_GO;
    end

    always_ff @(posedge Clock or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_rr      <= '0;
            r_timer   <= '0;
            r_route   <= '0;
            r_dir     <= '0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_pend_nx;
            r_rr      <= w_rr_nx;
            r_timer   <= w_timer_nx;
            r_route   <= w_route_nx;
            r_dir     <= w_dir_nx;
            r_busy    <= (w_state_nx == OCCUPIED);
            r_fault   <= (w_state_nx == FAULT);
        end
    end

    assign dir   = r_dir;
    assign route = r_route;
    assign busy  = r_busy;
    assign fault = r_fault;
endmodule

// File: tb/tb_train_section_interlock.sv
// tb_train_section_interlock: directed and random stimulus against a behavioural interlock model
module tb_train_section_interlock;
    localparam int N = 2, D = 2, T = 16;
    logic           Clock = 1'b0, RESET = 1'b1;
    logic [N-1:0]   entry_sr = '0, exit_sr = '0;
    logic [2*N-1:0] dir;
    logic           route, busy, fault;
    int             errors = 0, checks = 0;
    string          phase = "init";
    int             m_owner, m_rr, m_timer, m_route, c_en[N], c_ex[N];
    bit             m_fault, m_fresh, m_pend[N], v_en[N], v_ex[N];

    train_section_interlock #(.NUM_TRAINS(N), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .Clock(Clock), .RESET(RESET), .entry_sr(entry_sr), .exit_sr(exit_sr),
        .dir(dir), .route(route), .busy(busy), .fault(fault)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_timer = 0; m_route = 0; m_fault = 0; m_fresh = 1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; c_en[i] = 0; c_ex[i] = 0; v_en[i] = 0; v_ex[i] = 0;
        end
    endtask

    // one clock edge: interlock reacts to last edge's events, then debouncers sample the inputs
    task automatic model_edge(input logic [N-1:0] en, input logic [N-1:0] ex);
        bit bad = 0;
        m_fresh = 0;
        if (!m_fault) begin
            for (int i = 0; i < N; i++) begin
                if (v_ex[i] && i != m_owner) bad = 1;
                if (v_en[i] && i != m_owner) m_pend[i] = 1;
            end
            if (bad) m_fault = 1;
            else if (m_owner >= 0 && v_ex[m_owner]) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_owner >= 0) begin
                m_timer++;
                if (T != 0 && m_timer == T) m_fault = 1;
            end
            if (!m_fault && m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int j = (m_rr + k) % N;
                    if (m_pend[j]) begin
                        m_owner = j; m_route = j; m_pend[j] = 0; m_timer = 0;
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            v_en[i] = en[i] && c_en[i] == D - 1;
            v_ex[i] = ex[i] && c_ex[i] == D - 1;
            c_en[i] = en[i] ? ((c_en[i] < D) ? c_en[i] + 1 : D) : 0;
            c_ex[i] = ex[i] ? ((c_ex[i] < D) ? c_ex[i] + 1 : D) : 0;
        end
    endtask

    task automatic model_check(input string tag);
        logic [2*N-1:0] e_dir;
        for (int i = 0; i < N; i++)
            e_dir[2*i +: 2] = (m_fresh || m_fault || (m_owner >= 0 && i != m_owner && m_pend[i])) ? 2'b00 : 2'b01;
        chk({tag, "_dir"}, 32'(dir), 32'(e_dir));
        chk({tag, "_route"}, 32'(route), 32'(m_route));
        chk({tag, "_busy"}, 32'(busy), 32'(!m_fresh && !m_fault && m_owner >= 0));
        chk({tag, "_fault"}, 32'(fault), 32'(!m_fresh && m_fault));
    endtask

    task automatic step(input logic [N-1:0] en, input logic [N-1:0] ex);
        entry_sr = en;
        exit_sr  = ex;
        @(posedge Clock);
        model_edge(en, ex);
        #1 model_check("model");
    endtask

    task automatic step_n(input logic [N-1:0] en, input logic [N-1:0] ex, input int n);
        repeat (n) step(en, ex);
    endtask

    task automatic do_reset();
        entry_sr = '0;
        exit_sr  = '0;
        RESET    = 1'b1;
        model_reset();
        #1 model_check("rst_async");
        repeat (2) @(posedge Clock);
        #1 model_check("rst_hold");
        RESET = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r_en, r_ex;
        int h;
        phase = "reset";
        do_reset();
        chk("rst_dir", 32'(dir), 32'h0);
        step(2'b00, 2'b00);
        chk("first_dir", 32'(dir), 32'b0101);

        phase = "handover";
        step_n(2'b01, 2'b00, 3);
        chk("grant0_busy", 32'(busy), 32'd1);
        chk("grant0_route", 32'(route), 32'd0);
        chk("grant0_dir", 32'(dir), 32'b0101);
        step_n(2'b10, 2'b00, 3);
        chk("stop1_dir", 32'(dir), 32'b0001);
        step_n(2'b00, 2'b01, 3);
        chk("hand_route", 32'(route), 32'd1);
        chk("hand_busy", 32'(busy), 32'd1);
        chk("hand_dir", 32'(dir), 32'b0101);
        step(2'b00, 2'b00);
        step_n(2'b00, 2'b10, 3);
        chk("free_busy", 32'(busy), 32'd0);
        chk("free_dir", 32'(dir), 32'b0101);
        step(2'b00, 2'b00);

        phase = "contention";
        step_n(2'b11, 2'b00, 3);
        chk("c1_route", 32'(route), 32'd0);
        chk("c1_dir", 32'(dir), 32'b0001);
        step(2'b00, 2'b00);
        step_n(2'b00, 2'b01, 3);
        chk("c1_next_route", 32'(route), 32'd1);
        step(2'b00, 2'b00);
        step_n(2'b00, 2'b10, 3);
        chk("c1_idle_busy", 32'(busy), 32'd0);
        step(2'b00, 2'b00);
        step_n(2'b11, 2'b00, 3);
        chk("c2_route", 32'(route), 32'd0);
        chk("c2_dir", 32'(dir), 32'b0001);
        step(2'b00, 2'b00);
        step_n(2'b00, 2'b01, 3);
        step(2'b00, 2'b00);
        step_n(2'b00, 2'b10, 3);
        step(2'b00, 2'b00);

        phase = "glitch";
        step(2'b01, 2'b00);
        step_n(2'b00, 2'b00, 2);
        chk("g1_busy", 32'(busy), 32'd0);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        step(2'b01, 2'b00);
        step_n(2'b00, 2'b00, 2);
        chk("g2_busy", 32'(busy), 32'd0);
        chk("g2_dir", 32'(dir), 32'b0101);

        phase = "random";
        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int c = 0; c < 80; c += h) begin
                r_en = N'($urandom_range(0, 3));
                r_ex = (m_owner >= 0 && $urandom_range(0, 2) == 0) ? N'(1 << m_owner) :
                       ($urandom_range(0, 15) == 0) ? N'($urandom_range(1, 3)) : '0;
                h = $urandom_range(1, 4);
                step_n(r_en, r_ex, h);
            end
        end

        phase = "watchdog";
        do_reset();
        step(2'b00, 2'b00);
        step_n(2'b01, 2'b00, 3);
        chk("wd_busy", 32'(busy), 32'd1);
        step_n(2'b00, 2'b00, 15);
        chk("wd_before_fault", 32'(fault), 32'd0);
        step(2'b00, 2'b00);
        chk("wd_fault", 32'(fault), 32'd1);
        chk("wd_dir", 32'(dir), 32'b0000);
        chk("wd_busy_off", 32'(busy), 32'd0);
        step_n(2'b11, 2'b11, 3);
        chk("wd_latched", 32'(fault), 32'd1);
        chk("wd_latched_dir", 32'(dir), 32'b0000);
        do_reset();
        chk("wd_rst_fault", 32'(fault), 32'd0);
        step(2'b00, 2'b00);
        chk("wd_rst_dir", 32'(dir), 32'b0101);

        phase = "unauth";
        step_n(2'b00, 2'b10, 3);
        chk("idle_exit_fault", 32'(fault), 32'd1);
        chk("idle_exit_dir", 32'(dir), 32'b0000);
        do_reset();
        step(2'b00, 2'b00);
        step_n(2'b01, 2'b00, 3);
        step(2'b00, 2'b00);
        step_n(2'b00, 2'b10, 3);
        chk("occ_exit_fault", 32'(fault), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
